// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port between instruction fetch
// and load/store. Each access is a registered req/ack handshake with a
// variable-latency memory, guarded by a wait-cycle watchdog that aborts the
// access and raises a sticky error flag.
// Optional build macro: MEM_ARB_STARVE_GUARD_EN (periodically forces a fetch
// grant while data requests keep winning).
module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        dp_req,
    input  logic        dp_we,
    input  logic [31:0] dp_addr,
    input  logic [31:0] dp_wdata,
    output logic        dp_ready,
    output logic [31:0] dp_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUSY_I,
        S_BUSY_D,
        S_RESP_I,
        S_RESP_D
    } state_t;

    // Last wait-counter value before the watchdog fires.
    localparam logic [7:0]  TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    // Aborted fetches return a NOP so the pipeline stays well-formed.
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_wait_cnt;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_if_rdata;
    logic [31:0] r_dp_rdata;
    logic        r_err;

    logic        w_grant_i;
    logic        w_grant_d;
    logic        w_ack;
    logic        w_timeout;
    logic        w_force_fetch;
    logic        w_unused;

    // Address bit 31 is replaced by the requester tag, so the inputs' bit 31 is dropped.
    assign w_unused = ^{if_addr[31], dp_addr[31], 32'(STARVE_LIMIT)};

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [2:0] r_starve_cnt;

    assign w_force_fetch = if_req && (r_starve_cnt == 3'(STARVE_LIMIT));

    // Count back-to-back data grants that left a fetch waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= 3'd0;
        end else if (w_grant_i) begin
            r_starve_cnt <= 3'd0;
        end else if (w_grant_d) begin
            r_starve_cnt <= if_req ? r_starve_cnt + 3'd1 : 3'd0;
        end
    end
`else
    assign w_force_fetch = 1'b0;
`endif

    // Ack is only meaningful while the strobe is out.
    assign w_ack = r_mem_req && mem_ack;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, grant decision and completion/abort detection.
    always_comb begin
        w_state_next = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_force_fetch) begin
                    w_grant_i    = 1'b1;
                    w_state_next = S_BUSY_I;
                end else if (dp_req) begin
                    w_grant_d    = 1'b1;
                    w_state_next = S_BUSY_D;
                end else if (if_req) begin
                    w_grant_i    = 1'b1;
                    w_state_next = S_BUSY_I;
                end
            end
            S_BUSY_I, S_BUSY_D: begin
                // An ack in the expiry cycle still completes normally.
                if (w_ack || r_wait_cnt == TO_LAST) begin
                    w_timeout    = !w_ack;
                    w_state_next = (r_state == S_BUSY_I) ? S_RESP_I : S_RESP_D;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Memory-side registers, wait counter, returned data and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt  <= 8'd0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_if_rdata  <= 32'd0;
            r_dp_rdata  <= 32'd0;
            r_err       <= 1'b0;
        end else if (w_grant_d) begin
            r_wait_cnt  <= 8'd0;
            r_mem_req   <= 1'b1;
            r_mem_we    <= dp_we;
            r_mem_addr  <= {1'b1, dp_addr[30:0]};
            r_mem_wdata <= dp_wdata;
        end else if (w_grant_i) begin
            r_wait_cnt  <= 8'd0;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {1'b0, if_addr[30:0]};
            r_mem_wdata <= 32'd0;
        end else if (r_state == S_BUSY_I || r_state == S_BUSY_D) begin
            if (w_ack) begin
                r_mem_req <= 1'b0;
                if (r_state == S_BUSY_I) begin
                    r_if_rdata <= mem_rdata;
                end else begin
                    r_dp_rdata <= r_mem_we ? 32'd0 : mem_rdata;
                end
            end else if (w_timeout) begin
                r_mem_req <= 1'b0;
                r_err     <= 1'b1;
                if (r_state == S_BUSY_I) begin
                    r_if_rdata <= NOP_INSN;
                end else begin
                    r_dp_rdata <= 32'd0;
                end
            end else begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
        end
    end

    assign if_ready  = (r_state == S_RESP_I);
    assign dp_ready  = (r_state == S_RESP_D);
    assign busy      = (r_state != S_IDLE);
    assign if_rdata  = r_if_rdata;
    assign dp_rdata  = r_dp_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign err       = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single accesses plus
// hand-written contention, reset-abort and starvation sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        dp_req;
    logic        dp_we;
    logic [31:0] dp_addr;
    logic [31:0] dp_wdata;
    logic        dp_ready;
    logic [31:0] dp_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        busy;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT_CYCLES(16), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .dp_req(dp_req), .dp_we(dp_we), .dp_addr(dp_addr), .dp_wdata(dp_wdata),
        .dp_ready(dp_ready), .dp_rdata(dp_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy), .err(err)
    );

    typedef struct {
        logic        is_data;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_delay;   // BUSY cycles without ack before ack; >=16 means never
        logic [31:0] rdata_in;
        logic [31:0] exp_addr;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_busy;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic is_data, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input int ack_delay,
                                input logic [31:0] rdata_in, input logic [31:0] exp_addr,
                                input logic [31:0] exp_rdata, input int exp_lat,
                                input int exp_busy, input logic exp_err);
        vec_t v;
        v.is_data = is_data;  v.we = we;            v.addr = addr;
        v.wdata = wdata;      v.ack_delay = ack_delay; v.rdata_in = rdata_in;
        v.exp_addr = exp_addr; v.exp_rdata = exp_rdata; v.exp_lat = exp_lat;
        v.exp_busy = exp_busy; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic run_vec(input int i);
        vec_t v;
        int   nbusy;
        int   lat;
        bit   stable_bad;
        bit   seen;
        logic rdy;
        logic other_rdy;
        v = vecs[i];
        nbusy = 0; lat = 0; stable_bad = 0; seen = 0;
        @(posedge clk); #1;
        if (v.is_data) begin
            dp_req = 1'b1; dp_we = v.we; dp_addr = v.addr; dp_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            mem_ack = 1'b0;
            if (mem_req) begin
                nbusy++;
                if (nbusy == 1) begin
                    check($sformatf("v%0d mem_addr", i), mem_addr, v.exp_addr);
                    check($sformatf("v%0d mem_we", i), {31'd0, mem_we}, {31'd0, v.we});
                    if (v.we) check($sformatf("v%0d mem_wdata", i), mem_wdata, v.wdata);
                end
                if (mem_addr !== v.exp_addr || mem_we !== v.we || (v.we && mem_wdata !== v.wdata))
                    stable_bad = 1;
                if (nbusy - 1 == v.ack_delay) begin
                    mem_ack = 1'b1;
                    mem_rdata = v.rdata_in;
                end
            end
            rdy       = v.is_data ? dp_ready : if_ready;
            other_rdy = v.is_data ? if_ready : dp_ready;
            if (rdy) begin
                seen = 1;
                if_req = 1'b0; dp_req = 1'b0;
                check($sformatf("v%0d rdata", i), v.is_data ? dp_rdata : if_rdata, v.exp_rdata);
                check($sformatf("v%0d latency", i), lat, v.exp_lat);
                check($sformatf("v%0d busy_cycles", i), nbusy, v.exp_busy);
                check($sformatf("v%0d err", i), {31'd0, err}, {31'd0, v.exp_err});
                check($sformatf("v%0d other_ready", i), {31'd0, other_rdy}, 32'd0);
            end
        end
        if (!seen) begin
            if_req = 1'b0; dp_req = 1'b0;
            check($sformatf("v%0d ready_seen", i), 32'd0, 32'd1);
        end
        check($sformatf("v%0d addr_stable", i), {31'd0, stable_bad}, 32'd0);
        @(posedge clk); #1;
        check($sformatf("v%0d ready_pulse_end", i), {30'd0, if_ready, dp_ready}, 32'd0);
        check($sformatf("v%0d busy_fall", i), {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic exp_grant_d[10];
        logic got_grant_d[10];
        int   ng;
        int   cyc;
        logic prev_req;
        int   nbusy;
        bit   seen;

        // Fetch, store, load, ack-at-expiry load, timeout fetch, sticky-err load, bit-31 fetch.
        vecs[0] = mk(0, 0, 32'h0000_0040, 32'h0, 0, 32'h0050_0093, 32'h0000_0040, 32'h0050_0093, 2, 1, 0);
        vecs[1] = mk(1, 1, 32'h0000_0010, 32'hDEAD_BEEF, 3, 32'hFFFF_FFFF, 32'h8000_0010, 32'h0, 5, 4, 0);
        vecs[2] = mk(1, 0, 32'h0000_0020, 32'h0, 1, 32'h0000_1234, 32'h8000_0020, 32'h0000_1234, 3, 2, 0);
        vecs[3] = mk(1, 0, 32'h0000_0024, 32'h0, 15, 32'h0BAD_CAFE, 32'h8000_0024, 32'h0BAD_CAFE, 17, 16, 0);
        vecs[4] = mk(0, 0, 32'h0000_0044, 32'h0, 999, 32'h0, 32'h0000_0044, 32'h0000_0013, 17, 16, 1);
        vecs[5] = mk(1, 0, 32'h0000_0008, 32'h0, 0, 32'hCAFE_F00D, 32'h8000_0008, 32'hCAFE_F00D, 2, 1, 1);
        vecs[6] = mk(0, 0, 32'h8000_0100, 32'h0, 2, 32'h1111_2222, 32'h0000_0100, 32'h1111_2222, 4, 3, 1);

        reset = 1'b1; if_req = 1'b0; if_addr = 32'd0; dp_req = 1'b0; dp_we = 1'b0;
        dp_addr = 32'd0; dp_wdata = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst mem_req/we", {30'd0, mem_req, mem_we}, 32'd0);
        check("rst busy/err", {30'd0, busy, err}, 32'd0);
        check("rst ready", {30'd0, if_ready, dp_ready}, 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst mem_wdata", mem_wdata, 32'd0);
        check("rst rdata", if_rdata | dp_rdata, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(i);

        // Contention: load and fetch raised together; data goes first.
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h0000_0060;
        dp_req = 1'b1; dp_we = 1'b0; dp_addr = 32'h0000_0020;
        @(posedge clk); #1;
        check("cont first grant addr", mem_addr, 32'h8000_0020);
        check("cont first mem_req", {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h0000_1234;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check("cont dp_ready", {31'd0, dp_ready}, 32'd1);
        check("cont dp_rdata", dp_rdata, 32'h0000_1234);
        dp_req = 1'b0;
        @(posedge clk); #1;
        check("cont idle gap busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check("cont fetch grant addr", mem_addr, 32'h0000_0060);
        check("cont fetch mem_req", {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0093;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check("cont if_ready", {31'd0, if_ready}, 32'd1);
        check("cont if_rdata", if_rdata, 32'h0000_0093);
        if_req = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a store; a late ack must be ignored.
        dp_req = 1'b1; dp_we = 1'b1; dp_addr = 32'h0000_0030; dp_wdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        check("rstmid mem_req before", {31'd0, mem_req}, 32'd1);
        reset = 1'b1; dp_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rstmid busy", {31'd0, busy}, 32'd0);
        check("rstmid mem_req", {31'd0, mem_req}, 32'd0);
        check("rstmid err", {31'd0, err}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (dp_ready || mem_req || busy) seen = 1;
        end
        check("rstmid no activity", {31'd0, seen}, 32'd0);

        // Starvation: both requesters held continuously, zero-wait memory.
`ifdef MEM_ARB_STARVE_GUARD_EN
        for (int k = 0; k < 10; k++) exp_grant_d[k] = (k % 5 != 4);
`else
        for (int k = 0; k < 10; k++) exp_grant_d[k] = 1'b1;
`endif
        for (int k = 0; k < 10; k++) got_grant_d[k] = 1'bx;
        if_req = 1'b1; if_addr = 32'h0000_0200;
        dp_req = 1'b1; dp_we = 1'b0; dp_addr = 32'h0000_0300;
        mem_rdata = 32'h0;
        ng = 0; cyc = 0; prev_req = 1'b0;
        while (ng < 10 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            mem_ack = 1'b0;
            if (mem_req && !prev_req) begin
                got_grant_d[ng] = mem_addr[31];
                ng++;
            end
            if (mem_req) mem_ack = 1'b1;
            prev_req = mem_req;
        end
        for (int k = 0; k < 10; k++)
            check($sformatf("starve grant%0d is_data", k), {31'd0, got_grant_d[k]},
                  {31'd0, exp_grant_d[k]});
        if_req = 1'b0; dp_req = 1'b0;
        nbusy = 0;
        while (busy && nbusy < 10) begin
            @(posedge clk); #1;
            mem_ack = mem_req;
            nbusy++;
        end
        mem_ack = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
